// File: rtl/imem_loader_pkg.sv
// Shared types, error codes and small helpers for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CKSUM   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // States in which the loader is consuming the stream.
  function automatic logic is_active(input loader_state_t st);
    logic act;
    case (st)
      S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK: act = 1'b1;
      default:                                act = 1'b0;
    endcase
    return act;
  endfunction

  // Running XOR checksum over payload bytes.
  function automatic logic [7:0] cksum_next(input logic [7:0] cksum, input logic [7:0] data);
    return cksum ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_idle_timer.sv
// Counts consecutive cycles without stream activity; flags the cycle that reaches TIMEOUT.
module idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;

  // Idle-cycle counter: cleared when disabled or kicked, saturates at TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CW'(0);
    end else if (!enable || kick) begin
      cnt_r <= CW'(0);
    end else if (cnt_r != CW'(TIMEOUT - 1)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A kick in the same cycle wins over expiry.
  assign expired = enable & ~kick & (cnt_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed, XOR-checked image into byte-wide instruction memory
// and keeps the core held until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int          ADDR_W    = $clog2(MEM_BYTES) + 1;
  localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);

  loader_state_t     state_r, state_nx_s;
  logic [1:0]        err_code_r, err_code_nx_s;
  logic              s_ready_r, mem_we_r, core_hold_r, done_r, err_r;
  logic [31:0]       mem_addr_r;
  logic [7:0]        mem_wdata_r, cksum_r, len_hi_r;
  logic [ADDR_W-1:0] addr_r, last_addr_r, last_s;
  logic [15:0]       len_s;
  logic              xfer_s, start_ok_s, timeout_s;

  assign xfer_s     = s_valid & s_ready_r;
  assign start_ok_s = start & ~is_active(state_r);
  assign len_s      = {len_hi_r, s_data};
  // Address of the final payload byte, 4N-1; N is range-checked before it is used.
  assign last_s     = {len_s[ADDR_W-3:0], 2'b00} - ADDR_W'(1);

  idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (is_active(state_r)),
    .kick    (s_valid),
    .expired (timeout_s)
  );

  // Next-state and error-code selection; timeout overrides any stream event.
  always_comb begin
    state_nx_s    = state_r;
    err_code_nx_s = err_code_r;
    if (timeout_s) begin
      state_nx_s    = S_ERR;
      err_code_nx_s = ERR_TIMEOUT;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_nx_s    = S_LEN_HI;
            err_code_nx_s = ERR_NONE;
          end else begin
            state_nx_s = state_r;
          end
        end
        S_LEN_HI: begin
          if (xfer_s) state_nx_s = S_LEN_LO;
          else        state_nx_s = state_r;
        end
        S_LEN_LO: begin
          if (!xfer_s) begin
            state_nx_s = state_r;
          end else if (len_s > MAX_WORDS) begin
            state_nx_s    = S_ERR;
            err_code_nx_s = ERR_LEN;
          end else if (len_s == 16'd0) begin
            state_nx_s = S_CHECK;
          end else begin
            state_nx_s = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (xfer_s && (addr_r == last_addr_r)) state_nx_s = S_CHECK;
          else                                   state_nx_s = state_r;
        end
        S_CHECK: begin
          if (!xfer_s) begin
            state_nx_s = state_r;
          end else if (s_data == cksum_r) begin
            state_nx_s = S_DONE;
          end else begin
            state_nx_s    = S_ERR;
            err_code_nx_s = ERR_CKSUM;
          end
        end
        default: begin
          state_nx_s    = S_IDLE;
          err_code_nx_s = ERR_NONE;
        end
      endcase
    end
  end

  // State register and status outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      s_ready_r   <= 1'b0;
      core_hold_r <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      state_r     <= state_nx_s;
      s_ready_r   <= is_active(state_nx_s);
      core_hold_r <= (state_nx_s != S_DONE);
      done_r      <= (state_nx_s == S_DONE);
      err_r       <= (state_nx_s == S_ERR);
      err_code_r  <= err_code_nx_s;
    end
  end

  // Datapath: length capture, address/checksum tracking and the one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 8'd0;
      addr_r      <= ADDR_W'(0);
      last_addr_r <= ADDR_W'(0);
      cksum_r     <= 8'd0;
      len_hi_r    <= 8'd0;
    end else begin
      mem_we_r <= 1'b0;
      if (start_ok_s) begin
        addr_r  <= ADDR_W'(0);
        cksum_r <= 8'd0;
      end else if (xfer_s && (state_r == S_LEN_HI)) begin
        len_hi_r <= s_data;
      end else if (xfer_s && (state_r == S_LEN_LO)) begin
        last_addr_r <= last_s;
      end else if (xfer_s && (state_r == S_PAYLOAD) && !timeout_s) begin
        mem_we_r    <= 1'b1;
        mem_addr_r  <= {{(32-ADDR_W){1'b0}}, addr_r};
        mem_wdata_r <= s_data;
        cksum_r     <= cksum_next(cksum_r, s_data);
        addr_r      <= addr_r + ADDR_W'(1);
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  assign s_ready   = s_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign core_hold = core_hold_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_code  = err_code_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-position reference model, per-cycle compare, directed scenarios.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready, mem_we, core_hold, done, err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err), .err_code(err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame position arithmetic) ----------------
  bit          m_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_idle = 0;
  logic [15:0] m_n = 16'd0;
  logic [7:0]  m_xor = 8'd0;
  logic        e_ready = 1'b0, e_we = 1'b0, e_hold = 1'b1, e_done = 1'b0, e_err = 1'b0;
  logic [1:0]  e_code = 2'd0;
  logic [31:0] e_addr = 32'd0;
  logic [7:0]  e_wdata = 8'd0;

  task automatic conclude(input bit ok, input logic [1:0] code);
    m_busy = 1'b0;
    e_done = ok;
    e_err  = !ok;
    e_code = code;
    e_hold = !ok;
  endtask

  // Model advances on every rising edge from the inputs presented before it.
  always @(posedge clk) begin
    m_on = 1'b1;
    if (!rst_n) begin
      m_busy = 1'b0; m_idle = 0;
      e_ready = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_wdata = 8'd0;
      e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0; e_code = 2'd0;
    end else begin
      e_we = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_k = 0; m_xor = 8'd0; m_idle = 0;
          e_done = 1'b0; e_err = 1'b0; e_code = 2'd0; e_hold = 1'b1;
        end
      end else if (s_valid) begin
        m_idle = 0;
        if (m_k == 0) begin
          m_n[15:8] = s_data;
        end else if (m_k == 1) begin
          m_n[7:0] = s_data;
          if (m_n > 16'd16) conclude(1'b0, 2'd1);
        end else if (m_k < 2 + 4 * int'(m_n)) begin
          e_we = 1'b1; e_addr = 32'(m_k - 2); e_wdata = s_data;
          m_xor = m_xor ^ s_data;
        end else if (s_data == m_xor) begin
          conclude(1'b1, 2'd0);
        end else begin
          conclude(1'b0, 2'd2);
        end
        m_k++;
      end else begin
        m_idle++;
        if (m_idle >= 16) conclude(1'b0, 2'd3);
      end
      e_ready = m_busy;
    end
  end

  // ---------------- per-cycle compare and write log ----------------
  logic [7:0] img [0:63];
  int         wr_cnt = 0;

  // Compare all outputs against the model on the falling edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("s_ready",   32'(s_ready),   32'(e_ready));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("core_hold", 32'(core_hold), 32'(e_hold));
      chk("done",      32'(done),      32'(e_done));
      chk("err",       32'(err),       32'(e_err));
      chk("err_code",  32'(err_code),  32'(e_code));
      if (e_we) begin
        chk("mem_addr",  mem_addr,         e_addr);
        chk("mem_wdata", 32'(mem_wdata),   32'(e_wdata));
      end
      if (mem_we === 1'b1) begin
        img[mem_addr[5:0]] = mem_wdata;
        wr_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] good_pl [0:7] = '{8'h20, 8'h01, 8'hFF, 8'hFD, 8'h20, 8'h02, 8'h00, 8'h14};
  logic [7:0] alt_pl  [0:3] = '{8'h12, 8'h34, 8'h56, 8'h78};
  int         base;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_wait: s_ready=%b, expected 1 within 40 cycles", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] ck);
    send(8'h00); send(8'h02);
    for (int i = 0; i < 8; i++) send(good_pl[i]);
    send(ck);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_hold",    32'(core_hold), 32'd1);
    chk("rst_err",     32'(err), 32'd0);

    // Good load
    base = wr_cnt;
    pulse_start();
    send_good(8'h15);
    #1;
    chk("good_done",   32'(done), 32'd1);
    chk("good_hold",   32'(core_hold), 32'd0);
    chk("good_writes", 32'(wr_cnt - base), 32'd8);
    for (int i = 0; i < 8; i++) chk("good_img", 32'(img[i]), 32'(good_pl[i]));

    // Checksum error
    base = wr_cnt;
    pulse_start();
    send_good(8'h16);
    #1;
    chk("ck_err",    32'(err), 32'd1);
    chk("ck_code",   32'(err_code), 32'd2);
    chk("ck_hold",   32'(core_hold), 32'd1);
    chk("ck_writes", 32'(wr_cnt - base), 32'd8);

    // Length error
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h11);
    #1;
    chk("len_code",   32'(err_code), 32'd1);
    chk("len_ready",  32'(s_ready), 32'd0);
    chk("len_writes", 32'(wr_cnt - base), 32'd0);

    // Zero-length frame with toggling valid
    base = wr_cnt;
    pulse_start();
    send(8'h00); idle(1); send(8'h00); idle(1); send(8'h00);
    #1;
    chk("zero_done",   32'(done), 32'd1);
    chk("zero_writes", 32'(wr_cnt - base), 32'd0);
    idle(3);

    // Timeout: 15 idle cycles survive, 16 abort
    pulse_start();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    idle(15);
    chk("to15_err", 32'(err), 32'd0);
    send(8'hCC);
    idle(16);
    #1;
    chk("to16_err",  32'(err), 32'd1);
    chk("to16_code", 32'(err_code), 32'd3);

    // Reset in the middle of the payload
    pulse_start();
    send(8'h00); send(8'h02); send(8'h20); send(8'h01); send(8'hFF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_we",    32'(mem_we), 32'd0);
    chk("mid_rst_addr",  mem_addr, 32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_hold",  32'(core_hold), 32'd1);
    chk("mid_rst_ready", 32'(s_ready), 32'd0);

    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h01);
    for (int i = 0; i < 4; i++) send(alt_pl[i]);
    send(8'h08);
    #1;
    chk("post_rst_done",   32'(done), 32'd1);
    chk("post_rst_writes", 32'(wr_cnt - base), 32'd4);
    for (int i = 0; i < 4; i++) chk("post_rst_img", 32'(img[i]), 32'(alt_pl[i]));

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle MIPS core. It takes a byte stream over a valid/ready handshake and writes it into the byte-addressed, big-endian instruction memory through a byte write port, so the memory is no longer filled only by simulation initial blocks. It holds the core stalled until a complete, checksum-verified image has been written.

## Interface
- `MEM_BYTES`, 64: instruction memory size in bytes; maximum image is `MEM_BYTES/4` words.
- `TIMEOUT`, 16: number of consecutive cycles without `s_valid` that aborts an active load.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `s_valid` in 1: stream byte valid.
- `s_data` in 8: stream byte.
- `s_ready` out 1: loader accepts a byte; a transfer occurs when `s_valid && s_ready`.
- `mem_we` out 1: instruction-memory byte write enable.
- `mem_addr` out 32: byte address of the write.
- `mem_wdata` out 8: byte to write.
- `core_hold` out 1: stall/reset request to the core PC.
- `done` out 1: last load succeeded.
- `err` out 1: last load failed.
- `err_code` out 2: failure cause: 0 none, 1 length too large, 2 checksum mismatch, 3 timeout.

## Operation
- Stream frame:
  - LEN_HI, then LEN_LO: 16-bit word count N, MSB first.
  - 4N payload bytes in address order 0..4N-1. Each word goes MSB first, matching the big-endian byte layout of instruction memory.
  - One check byte: XOR of all payload bytes.
- State machine: IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK, DONE, ERR.
  - IDLE/DONE/ERR + `start` → LEN_HI. On this transition, `done`, `err` and `err_code` clear, the address counter resets to 0 and the checksum register resets to 0x00.
  - LEN_HI: transfer → LEN_LO.
  - LEN_LO: transfer; if N > `MEM_BYTES/4` → ERR (code 1); else if N == 0 → CHECK; else → PAYLOAD.
  - PAYLOAD: each transfer writes the byte at the address counter, XORs it into the checksum, and increments the counter. The transfer of byte 4N-1 → CHECK.
  - CHECK: transfer; byte equal to the checksum → DONE; otherwise → ERR (code 2).
  - LEN_HI..CHECK: the idle counter resets on every cycle with `s_valid` high and increments otherwise. Reaching `TIMEOUT` → ERR (code 3).
- `s_ready` = 1 exactly in LEN_HI, LEN_LO, PAYLOAD, CHECK; 0 otherwise.
- `core_hold` = 0 only in DONE; 1 in every other state, including ERR and IDLE.
- `start` in LEN_HI..CHECK is ignored.
- Address counter is `$clog2(MEM_BYTES)+1` bits and is zero-extended onto `mem_addr`. It cannot wrap, because N is bounded before PAYLOAD is entered.
- Bytes already written before an error are not rolled back; the core stays held.

## Timing
- Reset values:
  - state IDLE
  - `s_ready` 0
  - `mem_we` 0, `mem_addr` 0, `mem_wdata` 0
  - `core_hold` 1
  - `done` 0, `err` 0, `err_code` 0
- All outputs are registered.
- Write latency: `mem_we` is high for exactly one cycle, the cycle after the payload transfer, carrying that transfer's address and data. Back-to-back transfers produce back-to-back writes.
- `s_ready` changes in the cycle after a state transition. No transfer is accepted in the cycle the FSM enters DONE/ERR.
- `done`/`err` assert, and `core_hold` drops, in the cycle after the CHECK transfer.
- `start` in DONE: `core_hold` rises the next cycle.
- Timeout: ERR is entered on the `TIMEOUT`-th consecutive cycle with `s_valid` low. A `s_valid` on that same cycle wins and the counter resets.
- Reset mid-load: reset takes priority over every event, all outputs return to reset values next cycle, and any pending write is dropped.

## Structure
- Package `imem_loader_pkg`: state enum `loader_state_t`; error-code constants `ERR_NONE`, `ERR_LEN`, `ERR_CKSUM`, `ERR_TIMEOUT`.
- Sub-module `idle_timer` (parameter `TIMEOUT`; inputs `clk`, `rst_n`, `enable`, `kick`; output `expired`). It holds the timeout counter and is instantiated once.

## Test plan
- Good load:
  - Stimulus: `start`, then 00 02 20 01 FF FD 20 02 00 14 15.
  - Writes: addresses 0..7 get 20,01,FF,FD,20,02,00,14, each one cycle after its transfer.
  - After the last byte: `done`=1 and `core_hold`=0 one cycle after the 0x15 transfer.
- Checksum error: same frame with check byte 16. Response: `err`=1, `err_code`=2, `core_hold`=1; the 8 writes still occurred.
- Length error: `start`, 00 11. Response: ERR with code 1 after the second byte, `s_ready`=0, no writes.
- Zero-length frame with backpressure: `start`, 00 00 00 with `s_valid` toggling 1/0. Response: `done`=1, no `mem_we` pulses, no duplicated transfers.
- Timeout: 00 01 AA BB, then `s_valid` low 15 cycles, then high. Response: no error. Then low for 16 cycles: `err_code`=3.
- Reset mid-PAYLOAD: assert `rst_n`=0 for one cycle after the third payload byte. Response: all outputs at reset values. A following full load completes normally from address 0.
